// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Collects a byte stream over valid/ready, packs bytes little-endian into
// 32-bit words, writes them to consecutive word addresses of the instruction
// memory, and keeps the core in reset until the whole image has been written.

// Structural invariants of the loader outputs, kept apart from the datapath.
module imem_loader_checker (
  input logic       clk,
  input logic       rst_n,
  input logic       mem_we,
  input logic       byte_ready,
  input logic       done,
  input logic       cpu_rst_n,
  input logic       busy,
  input logic [1:0] addr_lsb
);

  // A write cycle never accepts a byte.
  a_we_not_ready: assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |-> !byte_ready);

  // Addresses presented to the memory are always word aligned.
  a_we_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |-> (addr_lsb == 2'b00));

  // Each word produces exactly one single-cycle write pulse.
  a_we_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    mem_we |=> !mem_we);

  // Once the image is complete the core runs and no session is active.
  a_done_release: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> (cpu_rst_n && !busy));

endmodule

module imem_loader #(
  parameter int ADD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [ADD:0] num_words,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic         byte_ready,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic         cpu_rst_n,
  output logic         busy,
  output logic         done,
  output logic         error
);

  // Largest image that fits: exactly 2**ADD words.
  localparam logic [ADD:0] MAX_WORDS = {1'b1, {ADD{1'b0}}};
  localparam logic [ADD:0] ONE_WORD  = {{ADD{1'b0}}, 1'b1};
  localparam logic [ADD:0] NO_WORDS  = {(ADD+1){1'b0}};
  localparam int           PAD_W     = 32 - ADD - 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;

  logic [ADD:0]  num_words_r;
  logic [ADD:0]  word_idx_r;
  logic [1:0]    byte_cnt_r;
  logic [23:0]   word_buf_r;     // lanes 0..2; lane 3 comes straight from byte_data
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_wdata_r;
  logic          error_r;

  logic          start_ok_s;     // start is only looked at in IDLE or DONE
  logic          start_err_s;    // image too large: rejected
  logic          start_zero_s;   // empty image: straight to DONE
  logic          start_go_s;     // real session begins
  logic          hs_s;           // byte handshake this cycle
  logic          last_byte_s;    // fourth byte of the current word
  logic          last_word_s;    // word being written is the final one

  // Word index to memory byte address; upper bits stay zero.
  function automatic logic [31:0] word_to_byte_addr(input logic [ADD:0] idx);
    return {{PAD_W{1'b0}}, idx, 2'b00};
  endfunction

  assign start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign start_err_s  = start_ok_s && (num_words > MAX_WORDS);
  assign start_zero_s = start_ok_s && !start_err_s && (num_words == NO_WORDS);
  assign start_go_s   = start_ok_s && !start_err_s && (num_words != NO_WORDS);
  assign hs_s         = (state_r == ST_RECV) && byte_valid;
  assign last_byte_s  = hs_s && (byte_cnt_r == 2'd3);
  assign last_word_s  = ((word_idx_r + ONE_WORD) == num_words_r);

  // State register; reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decision for the load session.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_go_s) begin
          state_s = ST_RECV;
        end else if (start_zero_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (last_byte_s) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (last_word_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_DONE: begin
        if (start_go_s) begin
          state_s = ST_RECV;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Session datapath: counters, byte packing, write-port registers, error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_words_r <= {(ADD+1){1'b0}};
      word_idx_r  <= {(ADD+1){1'b0}};
      byte_cnt_r  <= 2'd0;
      word_buf_r  <= 24'd0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      error_r     <= 1'b0;
    end else begin
      if (start_err_s) begin
        error_r <= 1'b1;
      end else if (start_go_s || start_zero_s) begin
        error_r <= 1'b0;
      end

      if (start_go_s) begin
        num_words_r <= num_words;
        word_idx_r  <= {(ADD+1){1'b0}};
        byte_cnt_r  <= 2'd0;
      end else if (state_r == ST_WRITE) begin
        word_idx_r  <= word_idx_r + ONE_WORD;
        byte_cnt_r  <= 2'd0;
      end else if (hs_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        case (byte_cnt_r)
          2'd0: word_buf_r[7:0]   <= byte_data;
          2'd1: word_buf_r[15:8]  <= byte_data;
          2'd2: word_buf_r[23:16] <= byte_data;
          2'd3: begin
            // Word complete: stage address and data for the WRITE cycle.
            mem_wdata_r <= {byte_data, word_buf_r};
            mem_addr_r  <= word_to_byte_addr(word_idx_r);
          end
          default: word_buf_r <= word_buf_r;
        endcase
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_rst_n  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        byte_ready = 1'b0;
      end
      ST_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
      end
      ST_DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      default: begin
        byte_ready = 1'b0;
      end
    endcase
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign error     = error_r;

  imem_loader_checker u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_we     (mem_we),
    .byte_ready (byte_ready),
    .done       (done),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .addr_lsb   (mem_addr_r[1:0])
  );

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: expected memory writes are queued as sessions
// are issued; a monitor pops and compares on every write pulse.
module tb_imem_loader;

  localparam int ADD = 8;
  localparam int CAP = 1 << ADD;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [ADD:0] num_words;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         cpu_rst_n;
  logic         busy;
  logic         done;
  logic         error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] img[CAP];
  bit          model_done;

  always #5 clk = ~clk;

  imem_loader #(.ADD(ADD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h expected=no write",
                 mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", mem_addr, mon_e.addr);
        chk("wr_data", mem_wdata, mon_e.data);
        chk1("wr_ready_low", byte_ready, 1'b0);
        chk1("wr_core_held", cpu_rst_n, 1'b0);
      end
    end
  end

  task automatic reset_check();
    chk1("rst_byte_ready", byte_ready, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk1("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
  endtask

  // Pulse start for one cycle and check the response one cycle later.
  task automatic do_start(input int n);
    @(posedge clk); #1;
    start     = 1'b1;
    num_words = n[ADD:0];
    @(posedge clk); #1;
    start = 1'b0;
    if (n > CAP) begin
      chk1("start_rej_error", error, 1'b1);
      chk1("start_rej_busy", busy, 1'b0);
      chk1("start_rej_ready", byte_ready, 1'b0);
      chk1("start_rej_done", done, model_done);
      chk1("start_rej_cpu", cpu_rst_n, model_done);
    end else if (n == 0) begin
      model_done = 1'b1;
      chk1("start_zero_done", done, 1'b1);
      chk1("start_zero_cpu", cpu_rst_n, 1'b1);
      chk1("start_zero_busy", busy, 1'b0);
      chk1("start_zero_error", error, 1'b0);
    end else begin
      model_done = 1'b0;
      chk1("start_go_busy", busy, 1'b1);
      chk1("start_go_ready", byte_ready, 1'b1);
      chk1("start_go_done", done, 1'b0);
      chk1("start_go_cpu", cpu_rst_n, 1'b0);
      chk1("start_go_error", error, 1'b0);
    end
  endtask

  // Offer one byte after 'gap' idle cycles; returns just after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int waited;
    int unsigned r;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    byte_data  = b;
    byte_valid = 1'b1;
    if (with_start) begin
      r         = $urandom_range(0, 511);
      start     = 1'b1;
      num_words = r[ADD:0];
    end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (byte_ready !== 1'b1 && waited < 100);
    if (byte_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout actual=no byte_ready expected=byte_ready within 100 cycles");
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Load img[0..n-1]; gap mode 0 = valid held high, 1 = toggling, 2 = random.
  task automatic run_image(input int n, input int mode, input bit midstart);
    logic [31:0] w;
    int gap;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: 32'(i) << 2, data: img[i]});
    end
    do_start(n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
        w   = img[i] >> (8 * k);
        send_byte(w[7:0], gap, midstart && (i == 0) && (k == 2));
      end
    end
    byte_valid = 1'b0;
    chk1("last_write_we", mem_we, 1'b1);
    chk1("last_write_not_done", done, 1'b0);
    @(posedge clk); #1;
    model_done = 1'b1;
    chk1("end_done", done, 1'b1);
    chk1("end_cpu_rst_n", cpu_rst_n, 1'b1);
    chk1("end_busy", busy, 1'b0);
    chk1("end_ready", byte_ready, 1'b0);
    chk1("end_we", mem_we, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    model_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_check();
    rst_n = 1'b1;

    // Reference image, valid held high, then toggling.
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    run_image(2, 0, 1'b0);
    run_image(2, 1, 1'b0);

    // Oversized request from IDLE after reset.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_done = 1'b0;
    do_start(CAP + 1);
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk1("idle_err_ready", byte_ready, 1'b0);
    chk1("idle_err_busy", busy, 1'b0);
    byte_valid = 1'b0;
    do_start(0);
    // Rejected start from DONE leaves done and the core untouched.
    do_start(300);

    // Reload one word from DONE: core goes back into reset, then released.
    img[0] = $urandom;
    run_image(1, 2, 1'b0);

    // Random images with random stalls and a stray start mid-stream.
    repeat (4) begin
      n = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      run_image(n, 2, 1'b1);
    end

    // Full capacity: last address is (2**ADD-1)<<2, no wrap.
    for (int i = 0; i < CAP; i++) img[i] = $urandom;
    run_image(CAP, 0, 1'b0);

    // Abort a partial word with reset, then load 0xDEADBEEF.
    do_start(1);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    byte_valid = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk); #1;
    reset_check();
    rst_n      = 1'b1;
    model_done = 1'b0;
    img[0] = 32'hDEAD_BEEF;
    run_image(1, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
